// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic DMEM_WRITE = 1'b1;
  localparam logic DMEM_READ  = 1'b0;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // A word must sit on a 4-byte boundary; a half in either lane on an even byte.
  function automatic logic dmem_misaligned(input logic [3:0] m, input logic [1:0] a_lo);
    logic half;
    half = (m == MASK_HALF) || (m == (MASK_HALF << 2));
    return ((m == MASK_WORD) && (a_lo != 2'b00)) || (half && a_lo[0]);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous byte-enabled single-port word RAM.
// Contents are deliberately not reset so the array maps onto block RAM.
module dmem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: request capture, wait states, response.
// Optional fault checking (range and alignment) is enabled by DMEM_ERR_CHECK_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        valid,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        err
);

  dmem_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [3:0]            mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  fault_q, fault_d;

  logic                  fault_in;
  logic                  mem_go;
  logic                  sel_idle;
  logic [31:0]           ram_rdata;
  logic                  unused_addr_bits;

`ifdef DMEM_ERR_CHECK_EN
  assign fault_in = (address[31:ADDR_WIDTH+2] != '0) || dmem_misaligned(mask, address[1:0]);
  assign err      = (state_q == RESP) && fault_q;
`else
  assign fault_in = 1'b0;
  assign err      = 1'b0;
`endif

  assign unused_addr_bits = ^{address[31:ADDR_WIDTH+2], address[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fault_d = fault_q;
    mem_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          we_d    = we_re;
          mask_d  = mask;
          addr_d  = address[ADDR_WIDTH+1:2];
          wdata_d = store_data;
          fault_d = fault_in;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            mem_go  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          mem_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= DMEM_READ;
      mask_q  <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
    end
  end

  // With zero wait states the access fires on the accepting edge, so it must
  // see the live request fields rather than the holding registers.
  assign sel_idle = (state_q == IDLE);

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .en   (mem_go && !(sel_idle ? fault_in : fault_q)),
    .we   (sel_idle ? we_re : we_q),
    .be   (sel_idle ? mask : mask_q),
    .addr (sel_idle ? address[ADDR_WIDTH+1:2] : addr_q),
    .wdata(sel_idle ? store_data : wdata_q),
    .rdata(ram_rdata)
  );

  assign valid     = (state_q == RESP);
  assign busy      = (state_q == WAIT) || (state_q == RESP);
  assign load_data = (valid && (we_q == DMEM_READ) && !fault_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed bench for dmem_ctrl (WAIT_CYCLES=1 and WAIT_CYCLES=0).
module tb_dmem_ctrl;

`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req1 = 1'b0;
  logic        req0 = 1'b0;
  logic        we_re = 1'b0;
  logic [3:0]  mask = 4'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] store_data = 32'd0;

  logic        valid1, busy1, err1, valid0, busy0, err0;
  logic [31:0] load_data1, load_data0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .request(req1), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data),
    .valid(valid1), .load_data(load_data1), .busy(busy1), .err(err1)
  );

  dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .request(req0), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data),
    .valid(valid0), .load_data(load_data0), .busy(busy0), .err(err0)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete handshake; checks latency, busy length, err and load_data.
  task automatic do_access(input bit sel0, input logic we, input logic [3:0] m,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_ld, input logic exp_e, input string nm);
    int cyc;
    int busy_n;
    int wc;
    bit got;
    wc = sel0 ? 0 : 1;
    we_re = we; mask = m; address = a; store_data = d;
    if (sel0) req0 = 1'b1; else req1 = 1'b1;
    cyc = 0; busy_n = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      cycle();
      cyc++;
      if (sel0 ? busy0 : busy1) busy_n++;
      if (sel0 ? valid0 : valid1) got = 1'b1;
    end
    check({nm, "_latency"}, cyc, 1 + wc);
    check({nm, "_busy"}, busy_n, 1 + wc);
    check({nm, "_err"}, sel0 ? err0 : err1, exp_e);
    check({nm, "_load"}, sel0 ? load_data0 : load_data1, exp_ld);
    req0 = 1'b0; req1 = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  m;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_ld;
    logic        exp_e;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int vcnt;
    bit got;

    vecs[0]  = '{1'b1, 4'b1111, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 4'b0010, 32'h10,   32'h0000AA00, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 32'h10,   32'h0,        32'hDEADAAEF, 1'b0};
    vecs[3]  = '{1'b1, 4'b0000, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 4'b0000, 32'h10,   32'h0,        32'hDEADAAEF, 1'b0};
    vecs[5]  = '{1'b1, 4'b1111, 32'h20,   32'hCAFEF00D, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 32'h20,   32'h0,        32'hCAFEF00D, 1'b0};
    vecs[7]  = '{1'b1, 4'b1000, 32'h23,   32'h77000000, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 4'b1100, 32'h22,   32'h55660000, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 32'h20,   32'h0,        32'h5566F00D, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 32'h22,   32'h0,        ERR_EN ? 32'h0 : 32'h5566F00D, ERR_EN};
    vecs[11] = '{1'b1, 4'b1111, 32'h00,   32'h01020304, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 4'b1111, 32'h1000, 32'hBAD0BAD0, 32'h0,        ERR_EN};
    vecs[13] = '{1'b0, 4'b1111, 32'h00,   32'h0,        ERR_EN ? 32'h01020304 : 32'hBAD0BAD0, 1'b0};

    // Reset state, both while held and just after release.
    @(negedge clk);
    check("rst_valid", valid1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_err", err1, 1'b0);
    check("rst_load", load_data1, 32'h0);
    check("rst_valid0", valid0, 1'b0);
    cycle();
    rst = 1'b1;
    cycle();
    check("post_rst_busy", busy1, 1'b0);
    check("post_rst_load", load_data1, 32'h0);

    for (int i = 0; i < 14; i++) begin
      do_access(1'b0, vecs[i].we, vecs[i].m, vecs[i].a, vecs[i].d,
                vecs[i].exp_ld, vecs[i].exp_e, $sformatf("vec%0d", i));
    end

    // Reset during WAIT aborts the write.
    we_re = 1'b1; mask = 4'b1111; address = 32'h20; store_data = 32'h12345678;
    req1 = 1'b1;
    cycle();
    check("rstw_busy_in_wait", busy1, 1'b1);
    rst = 1'b0;
    req1 = 1'b0;
    #1;
    check("rstw_busy_cleared", busy1, 1'b0);
    check("rstw_valid_cleared", valid1, 1'b0);
    cycle();
    rst = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (valid1) vcnt++;
    end
    check("rstw_no_valid", vcnt, 0);
    do_access(1'b0, 1'b0, 4'b1111, 32'h20, 32'h0, 32'h5566F00D, 1'b0, "rstw_readback");

    // Reset during RESP drops valid but the write stands.
    we_re = 1'b1; mask = 4'b1111; address = 32'h40; store_data = 32'hA5A5A5A5;
    req1 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (valid1) got = 1'b1;
    end
    check("rstr_reached_resp", got, 1'b1);
    #1;
    rst = 1'b0;
    req1 = 1'b0;
    #1;
    check("rstr_valid_dropped", valid1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    do_access(1'b0, 1'b0, 4'b1111, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b0, "rstr_readback");

    // Zero wait states: single access, then back-to-back reads with request held.
    do_access(1'b1, 1'b1, 4'b1111, 32'h10, 32'hDEADAAEF, 32'h0, 1'b0, "w0_write");
    we_re = 1'b0; mask = 4'b1111; address = 32'h10; store_data = 32'h0;
    req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check($sformatf("b2b_valid%0d", i), valid0, (i % 2) == 0);
      if ((i % 2) == 0) check($sformatf("b2b_load%0d", i), load_data0, 32'hDEADAAEF);
    end
    req0 = 1'b0;
    cycle();
    check("b2b_idle_after", busy0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
